// File: rtl/pc_branch_unit.sv
// Program counter and branch resolution around the ALU: flag capture, BEQ/BNE/JMP
// through a branch-target table, and the start/run/done program handshake.
module pc_branch_unit #(
    parameter int PC_W       = 10,
    parameter int IDX_W      = 5,
    parameter int START_ADDR = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             done,
    output logic             run,
    input  logic             halt,
    input  logic             flag_we,
    input  logic             alu_equal,
    input  logic             alu_zero,
    input  logic             alu_sc,
    input  logic             br_eq,
    input  logic             br_ne,
    input  logic             jmp,
    input  logic [IDX_W-1:0] lut_idx,
    input  logic             tgt_we,
    input  logic [IDX_W-1:0] tgt_waddr,
    input  logic [PC_W-1:0]  tgt_wdata,
    output logic [PC_W-1:0]  pc,
    output logic             taken,
    output logic             eq_flag,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int                LUT_N    = 2 ** IDX_W;
    localparam logic [PC_W-1:0]   START_PC = PC_W'(START_ADDR);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state, state_nx;
    logic [PC_W-1:0] pc_nx;
    logic [PC_W-1:0] lut [LUT_N];

    assign run  = (state == S_RUN);
    assign done = (state == S_DONE);

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        taken    = 1'b0;
        unique case (state)
            S_IDLE: begin
                pc_nx = START_PC;
                if (start) state_nx = S_RUN;
            end
            S_RUN: begin
                if (halt) begin
                    state_nx = S_DONE;
                end else begin
                    // Branch decision uses the registered eq_flag only; no forwarding.
                    if (jmp)        taken = 1'b1;
                    else if (br_eq) taken = eq_flag;
                    else if (br_ne) taken = ~eq_flag;
                    pc_nx = taken ? lut[lut_idx] : pc + 1'b1;
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_nx = S_IDLE;
                    pc_nx    = START_PC;
                end
            end
            default: begin
                state_nx = S_IDLE;
                pc_nx    = START_PC;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            pc         <= START_PC;
            eq_flag    <= 1'b0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
            cycle_cnt  <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            if (state == S_IDLE && start) begin
                eq_flag    <= 1'b0;
                zero_flag  <= 1'b0;
                carry_flag <= 1'b0;
                cycle_cnt  <= '0;
            end else if (state == S_RUN) begin
                if (cycle_cnt != CNT_MAX) cycle_cnt <= cycle_cnt + 1'b1;
                if (flag_we) begin
                    eq_flag    <= alu_equal;
                    zero_flag  <= alu_zero;
                    carry_flag <= alu_sc;
                end
            end
        end
    end

    // NOTE: the target table is cleared by reset because a jump after reset must land on 0,
    // which rules out an uninitialised RAM macro here.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LUT_N; i++) lut[i] <= '0;
        end else if (state == S_IDLE && tgt_we) begin
            lut[tgt_waddr] <= tgt_wdata;
        end
    end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the program sequencer.
module tb_pc_branch_unit;

    localparam int PC_MOD  = 1024;
    localparam int CNT_TOP = 65535;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DONE  = 2;

    logic       clk;
    logic       reset, start, halt, flag_we, alu_equal, alu_zero, alu_sc;
    logic       br_eq, br_ne, jmp, tgt_we;
    logic [4:0] lut_idx, tgt_waddr;
    logic [9:0] tgt_wdata;
    logic       done, run, taken, eq_flag, zero_flag, carry_flag;
    logic [9:0] pc;
    logic [15:0] cycle_cnt;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    int m_mode, m_pc, m_cnt;
    bit m_eq, m_zero, m_carry;
    int m_lut [32];

    pc_branch_unit dut (
        .clk(clk), .reset(reset), .start(start), .done(done), .run(run),
        .halt(halt), .flag_we(flag_we), .alu_equal(alu_equal), .alu_zero(alu_zero),
        .alu_sc(alu_sc), .br_eq(br_eq), .br_ne(br_ne), .jmp(jmp), .lut_idx(lut_idx),
        .tgt_we(tgt_we), .tgt_waddr(tgt_waddr), .tgt_wdata(tgt_wdata), .pc(pc),
        .taken(taken), .eq_flag(eq_flag), .zero_flag(zero_flag),
        .carry_flag(carry_flag), .cycle_cnt(cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic bit model_taken();
        if (m_mode != M_RUN || halt) return 1'b0;
        if (jmp) return 1'b1;
        if (br_eq) return m_eq;
        if (br_ne) return !m_eq;
        return 1'b0;
    endfunction

    function automatic void model_update();
        bit tk;
        tk = model_taken();
        if (reset) begin
            m_mode = M_IDLE; m_pc = 0; m_cnt = 0;
            m_eq = 0; m_zero = 0; m_carry = 0;
            foreach (m_lut[i]) m_lut[i] = 0;
            return;
        end
        case (m_mode)
            M_IDLE: begin
                m_pc = 0;
                if (tgt_we) m_lut[tgt_waddr] = int'(tgt_wdata);
                if (start) begin
                    m_mode = M_RUN; m_cnt = 0;
                    m_eq = 0; m_zero = 0; m_carry = 0;
                end
            end
            M_RUN: begin
                m_cnt = (m_cnt < CNT_TOP) ? m_cnt + 1 : CNT_TOP;
                if (halt)      m_mode = M_DONE;
                else if (tk)   m_pc = m_lut[lut_idx];
                else           m_pc = (m_pc + 1) % PC_MOD;
                if (flag_we) begin
                    m_eq = alu_equal; m_zero = alu_zero; m_carry = alu_sc;
                end
            end
            default: begin
                if (!start) begin
                    m_mode = M_IDLE; m_pc = 0;
                end
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        reset = 0; start = 0; halt = 0; flag_we = 0; alu_equal = 0; alu_zero = 0;
        alu_sc = 0; br_eq = 0; br_ne = 0; jmp = 0; tgt_we = 0;
        lut_idx = '0; tgt_waddr = '0; tgt_wdata = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
        checks++;
        if ({done, run, pc, eq_flag, zero_flag, carry_flag, cycle_cnt} !== 31'd0) begin
            failures++;
            $display("FAIL reset_state: got done=%b run=%b pc=%0d flags=%b%b%b cnt=%0d, want all 0",
                     done, run, pc, eq_flag, zero_flag, carry_flag, cycle_cnt);
        end
    endtask

    task automatic test_basic_run_and_jmp();
        tgt_we = 1; tgt_waddr = 5'd3; tgt_wdata = 10'd40;
        tick();
        tgt_we = 0;
        start = 1;
        tick();
        start = 0;
        checks++;
        if (run !== 1'b1 || pc !== 10'd0 || cycle_cnt !== 16'd0) begin
            failures++;
            $display("FAIL run_entry: got run=%b pc=%0d cnt=%0d, want run=1 pc=0 cnt=0", run, pc, cycle_cnt);
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (pc !== 10'(i) || cycle_cnt !== 16'(i)) begin
                failures++;
                $display("FAIL seq_pc_%0d: got pc=%0d cnt=%0d, want pc=%0d cnt=%0d", i, pc, cycle_cnt, i, i);
            end
        end
        jmp = 1; lut_idx = 5'd3;
        #1;
        checks++;
        if (taken !== 1'b1) begin
            failures++;
            $display("FAIL jmp_taken: got taken=%b, want 1", taken);
        end
        tick();
        jmp = 0;
        checks++;
        if (pc !== 10'd40) begin
            failures++;
            $display("FAIL jmp_target: got pc=%0d, want 40", pc);
        end
        tick();
        checks++;
        if (pc !== 10'd41) begin
            failures++;
            $display("FAIL after_jmp: got pc=%0d, want 41", pc);
        end
    endtask

    task automatic test_cond_branches();
        flag_we = 1; alu_equal = 1; alu_zero = 1; alu_sc = 1;
        tick();
        flag_we = 0; alu_equal = 0; alu_zero = 0; alu_sc = 0;
        checks++;
        if ({eq_flag, zero_flag, carry_flag} !== 3'b111) begin
            failures++;
            $display("FAIL flag_capture: got %b%b%b, want 111", eq_flag, zero_flag, carry_flag);
        end
        br_eq = 1; lut_idx = 5'd3;
        tick();
        br_eq = 0;
        checks++;
        if (pc !== 10'd40) begin
            failures++;
            $display("FAIL beq_taken: got pc=%0d, want 40", pc);
        end
        flag_we = 1; alu_equal = 0;
        tick();
        flag_we = 0;
        br_ne = 1;
        tick();
        br_ne = 0;
        checks++;
        if (pc !== 10'd40 || eq_flag !== 1'b0) begin
            failures++;
            $display("FAIL bne_taken: got pc=%0d eq=%b, want pc=40 eq=0", pc, eq_flag);
        end
        br_eq = 1;
        #1;
        checks++;
        if (taken !== 1'b0) begin
            failures++;
            $display("FAIL beq_not_taken_flag: got taken=%b, want 0", taken);
        end
        tick();
        br_eq = 0;
        checks++;
        if (pc !== 10'd41) begin
            failures++;
            $display("FAIL beq_not_taken: got pc=%0d, want 41", pc);
        end
    endtask

    task automatic test_no_forward_and_halt_priority();
        flag_we = 1; alu_equal = 1; br_eq = 1; lut_idx = 5'd3;
        #1;
        checks++;
        if (taken !== 1'b0) begin
            failures++;
            $display("FAIL no_forward_taken: got taken=%b, want 0", taken);
        end
        tick();
        flag_we = 0; alu_equal = 0; br_eq = 0;
        checks++;
        if (pc !== 10'd42 || eq_flag !== 1'b1) begin
            failures++;
            $display("FAIL no_forward: got pc=%0d eq=%b, want pc=42 eq=1", pc, eq_flag);
        end
        halt = 1; jmp = 1;
        #1;
        checks++;
        if (taken !== 1'b0) begin
            failures++;
            $display("FAIL halt_over_jmp_taken: got taken=%b, want 0", taken);
        end
        tick();
        halt = 0; jmp = 0;
        checks++;
        if (done !== 1'b1 || run !== 1'b0 || pc !== 10'd42) begin
            failures++;
            $display("FAIL halt_over_jmp: got done=%b run=%b pc=%0d, want done=1 run=0 pc=42", done, run, pc);
        end
        tick();
        checks++;
        if (done !== 1'b0 || pc !== 10'd0) begin
            failures++;
            $display("FAIL done_to_idle: got done=%b pc=%0d, want done=0 pc=0", done, pc);
        end
    endtask

    task automatic test_wrap_and_done();
        tgt_we = 1; tgt_waddr = 5'd1; tgt_wdata = 10'd1023;
        tick();
        tgt_we = 0;
        start = 1;
        tick();
        start = 0;
        jmp = 1; lut_idx = 5'd1;
        tick();
        jmp = 0;
        checks++;
        if (pc !== 10'd1023) begin
            failures++;
            $display("FAIL jmp_1023: got pc=%0d, want 1023", pc);
        end
        tick();
        checks++;
        if (pc !== 10'd0) begin
            failures++;
            $display("FAIL pc_wrap: got pc=%0d, want 0", pc);
        end
        repeat (7) tick();
        halt = 1;
        tick();
        halt = 0;
        checks++;
        if (done !== 1'b1 || pc !== 10'd7 || cycle_cnt !== 16'd10) begin
            failures++;
            $display("FAIL halt_at_7: got done=%b pc=%0d cnt=%0d, want done=1 pc=7 cnt=10", done, pc, cycle_cnt);
        end
        start = 1; br_eq = 1; jmp = 1; flag_we = 1; alu_equal = 1;
        repeat (3) tick();
        br_eq = 0; jmp = 0; flag_we = 0; alu_equal = 0;
        checks++;
        if (done !== 1'b1 || pc !== 10'd7 || cycle_cnt !== 16'd10 || eq_flag !== 1'b0) begin
            failures++;
            $display("FAIL done_hold: got done=%b pc=%0d cnt=%0d eq=%b, want done=1 pc=7 cnt=10 eq=0",
                     done, pc, cycle_cnt, eq_flag);
        end
        start = 0;
        tick();
        checks++;
        if (done !== 1'b0 || run !== 1'b0 || pc !== 10'd0) begin
            failures++;
            $display("FAIL back_to_idle: got done=%b run=%b pc=%0d, want 0 0 0", done, run, pc);
        end
    endtask

    task automatic test_reset_mid_run();
        start = 1;
        tick();
        start = 0;
        flag_we = 1; alu_equal = 1;
        tick();
        flag_we = 0; alu_equal = 0;
        repeat (11) tick();
        checks++;
        if (pc !== 10'd12 || eq_flag !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset: got pc=%0d eq=%b, want pc=12 eq=1", pc, eq_flag);
        end
        reset = 1;
        tick();
        reset = 0;
        checks++;
        if (run !== 1'b0 || done !== 1'b0 || pc !== 10'd0 || eq_flag !== 1'b0 || cycle_cnt !== 16'd0) begin
            failures++;
            $display("FAIL mid_run_reset: got run=%b done=%b pc=%0d eq=%b cnt=%0d, want all 0",
                     run, done, pc, eq_flag, cycle_cnt);
        end
        start = 1;
        tick();
        start = 0;
        jmp = 1; lut_idx = 5'd3;
        tick();
        jmp = 0;
        checks++;
        if (pc !== 10'd0) begin
            failures++;
            $display("FAIL lut_cleared: got pc=%0d, want 0", pc);
        end
    endtask

    task automatic test_random();
        bit exp_tk;
        logic [30:0] exp_v, got_v;
        reset = 1;
        tick();
        for (int n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(0, 299) == 0);
            start     = ($urandom_range(0, 3) != 0);
            halt      = ($urandom_range(0, 24) == 0);
            flag_we   = $urandom_range(0, 1);
            alu_equal = $urandom_range(0, 1);
            alu_zero  = $urandom_range(0, 1);
            alu_sc    = $urandom_range(0, 1);
            br_eq     = ($urandom_range(0, 3) == 0);
            br_ne     = ($urandom_range(0, 3) == 0);
            jmp       = ($urandom_range(0, 7) == 0);
            lut_idx   = 5'($urandom_range(0, 31));
            tgt_we    = $urandom_range(0, 1);
            tgt_waddr = 5'($urandom_range(0, 31));
            tgt_wdata = 10'($urandom_range(0, 1023));
            #1;
            exp_tk = model_taken();
            checks++;
            if (taken !== exp_tk) begin
                failures++;
                $display("FAIL rand_taken[%0d]: got %b, want %b", n, taken, exp_tk);
            end
            tick();
            exp_v = {m_mode == M_DONE, m_mode == M_RUN, 10'(m_pc), m_eq, m_zero, m_carry, 16'(m_cnt)};
            got_v = {done, run, pc, eq_flag, zero_flag, carry_flag, cycle_cnt};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL rand_state[%0d]: got done/run/pc/flags/cnt=%h, want %h", n, got_v, exp_v);
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        @(negedge clk);
        test_reset();
        test_basic_run_and_jmp();
        test_cond_branches();
        test_no_forward_and_halt_priority();
        test_wrap_and_done();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Program-counter and branch-resolution stage wrapped around the ALU.
- Captures the ALU status flags (equal, zero, shift-carry) on compare instructions and resolves BEQ/BNE/JMP through a 32-entry branch-target lookup table.
- Drives the fetch address and provides the start/done program handshake to the top-level harness.

Parameters:
- PC_W, 10, program counter / instruction address width
- IDX_W, 5, branch-target LUT index width (2**IDX_W entries)
- START_ADDR, 0, PC value loaded on reset and on IDLE->RUN
- CNT_W, 16, width of the run-cycle counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  level request to begin program execution
- done  out  1  program halted; high in DONE state
- run  out  1  high in RUN state; fetch/execute enable
- halt  in  1  decoded halt instruction this cycle
- flag_we  in  1  compare instruction this cycle; capture ALU flags
- alu_equal  in  1  ALU equal output
- alu_zero  in  1  ALU zero output
- alu_sc  in  1  ALU shift-carry output
- br_eq  in  1  branch if eq_flag==1
- br_ne  in  1  branch if eq_flag==0
- jmp  in  1  unconditional branch
- lut_idx  in  IDX_W  branch-target LUT index from instruction
- tgt_we  in  1  LUT write enable
- tgt_waddr  in  IDX_W  LUT write index
- tgt_wdata  in  PC_W  LUT write data (absolute target)
- pc  out  PC_W  current instruction address (registered)
- taken  out  1  combinational; next PC is a branch target
- eq_flag  out  1  registered equal flag
- zero_flag  out  1  registered zero flag
- carry_flag  out  1  registered shift-carry flag
- cycle_cnt  out  CNT_W  RUN cycles since last IDLE->RUN

Behaviour:
- All state changes occur on the rising edge of clk. Reset is synchronous, active-high, and overrides all other inputs.
- Reset values:
  - state=IDLE, pc=START_ADDR, done=0, run=0
  - eq_flag, zero_flag, carry_flag = 0
  - cycle_cnt=0
  - all LUT entries = 0
- IDLE:
  - run=0, done=0, pc held at START_ADDR.
  - tgt_we writes LUT[tgt_waddr]=tgt_wdata.
  - start=1 -> RUN next cycle; pc=START_ADDR, cycle_cnt=0, flags cleared.
- RUN:
  - run=1. Each cycle the controls are sampled and pc updates at the edge (one-cycle latency).
  - Priority: halt > jmp > br_eq > br_ne.
  - halt: -> DONE; pc holds.
  - jmp, or br_eq with eq_flag=1, or br_ne with eq_flag=0: pc<=LUT[lut_idx], taken=1.
  - Otherwise: pc<=pc+1, wrapping from 2**PC_W-1 to 0. taken=0.
  - taken is 0 whenever halt=1 or state!=RUN.
  - flag_we=1: eq/zero/carry flags <= alu_equal/alu_zero/alu_sc.
  - A branch sampled in the same cycle as flag_we uses the old (registered) eq_flag; there is no forwarding.
  - cycle_cnt increments every RUN cycle, including the halt cycle, and saturates at all-ones.
  - tgt_we is ignored.
- DONE:
  - done=1, run=0. pc, flags and cycle_cnt are held.
  - tgt_we is ignored.
  - start=0 -> IDLE. While start stays 1, remain in DONE; start is not re-triggered until it has been low.
- Reset in any state: immediate return to the reset values at the next edge, LUT included.
- Flag and branch inputs are ignored outside RUN.

Test Plan:
- Reset, load LUT[3]=10'd40 in IDLE, start=1 for 1 cycle -> pc 0,1,2,3 on successive cycles, run=1, cycle_cnt tracks.
- At pc=5, jmp=1, lut_idx=3 -> taken=1 that cycle; pc=40 next cycle, then 41.
- flag_we=1 with alu_equal=1, next cycle br_eq=1, idx=3 -> eq_flag=1, pc=40. Repeat with alu_equal=0 and br_ne -> pc=40; br_eq with eq_flag=0 -> pc+1.
- Same cycle: flag_we=1, alu_equal=1, br_eq=1, with prior eq_flag=0 -> not taken (pc+1), eq_flag=1 afterwards. Same cycle: halt=1 and jmp=1 -> DONE, pc held, taken=0.
- LUT[0]=0 with pc at 1023 and no branch -> pc wraps to 0. halt at pc=7 -> done=1, pc=7 held; start kept 1 stays DONE, start=0 -> IDLE, pc=0.
- Assert reset mid-RUN at pc=12 with eq_flag=1 -> next edge: IDLE, pc=0, flags 0, LUT[3] reads 0 on a later jmp, cycle_cnt=0.
